// File: rtl/pipe_pkg.sv
// Types and constants shared across the RV32 pipeline stages.
// BUS_WIDTH is a module parameter; XLEN here fixes the width of the IF/ID handoff struct.
package pipe_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter register with async reset.
// A load takes priority over an increment; the increment wraps modulo 2^W.
module pc_reg #(
  parameter int            W            = 32,
  parameter logic [W-1:0]  RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] pc_o
);
  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (en_i) begin
      pc_d = pc_q + W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC ownership, boot delay, stall/redirect/halt control and the IF/ID register.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects halt the core and set a sticky flag.
module instr_fetch #(
  parameter int                    BUS_WIDTH    = 32,
  parameter logic [BUS_WIDTH-1:0]  RESET_VECTOR = pipe_pkg::RESET_VECTOR,
  parameter int                    BOOT_CYCLES  = 2,
  parameter logic [BUS_WIDTH-1:0]  NOP_INST     = pipe_pkg::NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [BUS_WIDTH-1:0] redirect_pc_i,
  input  logic                 halt_req_i,
  output logic [BUS_WIDTH-1:0] imem_addr_o,
  input  logic [BUS_WIDTH-1:0] imem_inst_i,
  output logic [BUS_WIDTH-1:0] if_pc_o,
  output logic [BUS_WIDTH-1:0] if_inst_o,
  output logic                 if_valid_o,
  output logic                 halted_o,
  output logic                 misalign_o
);
  import pipe_pkg::*;

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

  fetch_state_t         state_q, state_d;
  logic [CNT_W-1:0]     boot_cnt_q, boot_cnt_d;
  logic [BUS_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [BUS_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                 if_valid_q, if_valid_d;
  logic                 misalign_q, misalign_d;

  logic                 pc_en;
  logic                 pc_load;
  logic [BUS_WIDTH-1:0] pc_load_val;
  logic [BUS_WIDTH-1:0] pc;
  logic                 redirect_misaligned;

  pc_reg #(
    .W            (BUS_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .en_i       (pc_en),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .pc_o       (pc)
  );

  // Low address bits are cleared on load, so an unchecked misaligned target lands on its word.
  assign pc_load_val = redirect_pc_i & ~BUS_WIDTH'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
  assign redirect_misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;
    pc_en      = 1'b0;
    pc_load    = 1'b0;

    case (state_q)
      BOOT: begin
        if_valid_d = 1'b0;
        boot_cnt_d = boot_cnt_q + CNT_W'(1);
        if (boot_cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt_req_i) begin
          state_d    = HALT;
          if_inst_d  = NOP_INST;
          if_valid_d = 1'b0;
        end else if (redirect_i) begin
          // The word fetched this cycle is wrong-path; replace it with a bubble.
          if_inst_d  = NOP_INST;
          if_valid_d = 1'b0;
          if (redirect_misaligned) begin
            state_d    = HALT;
            misalign_d = 1'b1;
          end else begin
            pc_load = 1'b1;
          end
        end else if (!stall_i) begin
          if_pc_d    = pc;
          if_inst_d  = imem_inst_i;
          if_valid_d = 1'b1;
          pc_en      = 1'b1;
        end
      end
      HALT: begin
        if_inst_d  = NOP_INST;
        if_valid_d = 1'b0;
      end
      default: begin
        state_d    = HALT;
        if_inst_d  = NOP_INST;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr_o = pc;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_valid_o  = if_valid_q;
  assign halted_o    = (state_q == HALT);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational memory returning 0x1000_0000 + address.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        halt_req_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        halted_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_inst_i = 32'h1000_0000 + imem_addr_o;

  instr_fetch #(
    .BUS_WIDTH    (32),
    .RESET_VECTOR (32'h0000_0000),
    .BOOT_CYCLES  (2),
    .NOP_INST     (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_req_i    (halt_req_i),
    .imem_addr_o   (imem_addr_o),
    .imem_inst_i   (imem_inst_i),
    .if_pc_o       (if_pc_o),
    .if_inst_o     (if_inst_o),
    .if_valid_o    (if_valid_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    halt_req_i    = 1'b0;
  endtask

  // Reset, release away from an edge, then wait out the two boot cycles.
  task automatic reset_and_boot();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total++;
    if (imem_addr_o !== 32'h0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h13 ||
        if_valid_o !== 1'b0 || halted_o !== 1'b0 || misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: addr=%h pc=%h inst=%h v=%b h=%b m=%b, want 0 0 13 0 0 0",
               imem_addr_o, if_pc_o, if_inst_o, if_valid_o, halted_o, misalign_o);
    end
  endtask

  task automatic test_boot_run();
    rst = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      step();
      total++;
      if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h0) begin
        bad++;
        $display("FAIL boot_edge%0d: valid=%b addr=%h, want 0 0", e, if_valid_o, imem_addr_o);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (if_pc_o !== 32'(4 * k) || if_inst_o !== 32'h1000_0000 + 32'(4 * k) || if_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL run_fetch%0d: pc=%h inst=%h v=%b, want %h %h 1", k, if_pc_o, if_inst_o,
                 if_valid_o, 32'(4 * k), 32'h1000_0000 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    step();
    total++;
    if (imem_addr_o !== 32'h10 || if_pc_o !== 32'hC) begin
      bad++;
      $display("FAIL stall_setup: addr=%h pc=%h, want 10 c", imem_addr_o, if_pc_o);
    end
    stall_i = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      total++;
      if (imem_addr_o !== 32'h10 || if_pc_o !== 32'hC || if_inst_o !== 32'h1000_000C || if_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d: addr=%h pc=%h inst=%h v=%b, want 10 c 1000000c 1",
                 e, imem_addr_o, if_pc_o, if_inst_o, if_valid_o);
      end
    end
    stall_i = 1'b0;
    step();
    total++;
    if (if_pc_o !== 32'h10 || if_inst_o !== 32'h1000_0010 || if_valid_o !== 1'b1 || imem_addr_o !== 32'h14) begin
      bad++;
      $display("FAIL stall_resume: pc=%h inst=%h v=%b addr=%h, want 10 10000010 1 14",
               if_pc_o, if_inst_o, if_valid_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    stall_i       = 1'b1;
    step();
    total++;
    if (if_valid_o !== 1'b0 || if_inst_o !== 32'h13 || imem_addr_o !== 32'h40) begin
      bad++;
      $display("FAIL redirect_bubble: v=%b inst=%h addr=%h, want 0 13 40", if_valid_o, if_inst_o, imem_addr_o);
    end
    clear_inputs();
    step();
    total++;
    if (if_pc_o !== 32'h40 || if_inst_o !== 32'h1000_0040 || if_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL redirect_target: pc=%h inst=%h v=%b, want 40 10000040 1", if_pc_o, if_inst_o, if_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h80;
    step();
    total++;
    if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h80) begin
      bad++;
      $display("FAIL b2b_first: v=%b addr=%h, want 0 80", if_valid_o, imem_addr_o);
    end
    redirect_pc_i = 32'h100;
    step();
    total++;
    if (if_valid_o !== 1'b0 || if_inst_o !== 32'h13 || imem_addr_o !== 32'h100) begin
      bad++;
      $display("FAIL b2b_second: v=%b inst=%h addr=%h, want 0 13 100", if_valid_o, if_inst_o, imem_addr_o);
    end
    clear_inputs();
    step();
    total++;
    if (if_pc_o !== 32'h100 || if_valid_o !== 1'b1 || if_inst_o !== 32'h1000_0100) begin
      bad++;
      $display("FAIL b2b_target: pc=%h v=%b inst=%h, want 100 1 10000100", if_pc_o, if_valid_o, if_inst_o);
    end
  endtask

  task automatic test_misalign();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h42;
    step();
    clear_inputs();
`ifdef FETCH_MISALIGN_CHECK_EN
    total++;
    if (misalign_o !== 1'b1 || halted_o !== 1'b1 || if_valid_o !== 1'b0 || imem_addr_o !== 32'h104) begin
      bad++;
      $display("FAIL misalign_halt: m=%b h=%b v=%b addr=%h, want 1 1 0 104",
               misalign_o, halted_o, if_valid_o, imem_addr_o);
    end
    step();
    total++;
    if (misalign_o !== 1'b1 || halted_o !== 1'b1) begin
      bad++;
      $display("FAIL misalign_sticky: m=%b h=%b, want 1 1", misalign_o, halted_o);
    end
`else
    total++;
    if (imem_addr_o !== 32'h40 || if_valid_o !== 1'b0 || misalign_o !== 1'b0 || halted_o !== 1'b0) begin
      bad++;
      $display("FAIL misalign_align: addr=%h v=%b m=%b h=%b, want 40 0 0 0",
               imem_addr_o, if_valid_o, misalign_o, halted_o);
    end
    step();
    total++;
    if (if_pc_o !== 32'h40 || if_valid_o !== 1'b1 || if_inst_o !== 32'h1000_0040) begin
      bad++;
      $display("FAIL misalign_fetch: pc=%h v=%b inst=%h, want 40 1 10000040", if_pc_o, if_valid_o, if_inst_o);
    end
`endif
    reset_and_boot();
    total++;
    if (misalign_o !== 1'b0 || halted_o !== 1'b0) begin
      bad++;
      $display("FAIL misalign_rst_clear: m=%b h=%b, want 0 0", misalign_o, halted_o);
    end
  endtask

  task automatic test_halt();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h20;
    step();
    clear_inputs();
    halt_req_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h60;
    step();
    total++;
    if (halted_o !== 1'b1 || if_valid_o !== 1'b0 || if_inst_o !== 32'h13 || imem_addr_o !== 32'h20) begin
      bad++;
      $display("FAIL halt_enter: h=%b v=%b inst=%h addr=%h, want 1 0 13 20",
               halted_o, if_valid_o, if_inst_o, imem_addr_o);
    end
    halt_req_i = 1'b0;
    for (int e = 0; e < 3; e++) begin
      redirect_i    = e[0];
      stall_i       = ~e[0];
      redirect_pc_i = 32'h200 + 32'(e * 4);
      step();
      total++;
      if (halted_o !== 1'b1 || if_valid_o !== 1'b0 || imem_addr_o !== 32'h20) begin
        bad++;
        $display("FAIL halt_absorb%0d: h=%b v=%b addr=%h, want 1 0 20", e, halted_o, if_valid_o, imem_addr_o);
      end
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (halted_o !== 1'b0 || imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL halt_rst_clear: h=%b addr=%h, want 0 0", halted_o, imem_addr_o);
    end
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h13 ||
        imem_addr_o !== 32'h0 || halted_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: v=%b pc=%h inst=%h addr=%h h=%b, want 0 0 13 0 0",
               if_valid_o, if_pc_o, if_inst_o, imem_addr_o, halted_o);
    end
    step();
    rst = 1'b0;
    step();
    step();
    step();
    total++;
    if (if_pc_o !== 32'h0 || if_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL async_reboot: pc=%h v=%b, want 0 1", if_pc_o, if_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misalign();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
